// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle decoder: FSM state encoding and the
// default sizing of the synchroniser and the two event counters.
package toggle_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PEND_W      = 4;
  localparam int DEF_TOT_W       = 16;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level.
//   clk   : sampling clock
//   reset : synchronous active-high reset, clears every stage to 0
//   d     : asynchronous input level
//   q     : synchronised level (last stage of the chain)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// Decodes a toggle-encoded event line (each level change of t_in is one
// event) into a pending-event counter with a valid/ready pop interface.
//   clk       : sole clock
//   reset     : synchronous active-high reset
//   t_in      : asynchronous toggle level
//   evt_valid : at least one event pending
//   evt_ready : consumer pops one event when high together with evt_valid
//   pend_cnt  : number of pending events (saturates, excess is dropped)
//   overflow  : sticky, an event was dropped while pend_cnt was full
//   clr_ovf   : clears overflow (a simultaneous new overflow wins)
//   total_cnt : all detected events including dropped ones, wrapping
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | synchroniser filling after reset, edges ignored
// RUN   | t_sync compared with t_prev every cycle, edges counted
module toggle_decoder
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PEND_W      = DEF_PEND_W,
  parameter int TOT_W       = DEF_TOT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [TOT_W-1:0]  total_cnt
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SYNC_STAGES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] init_cnt, init_cnt_nxt;
  logic             t_sync;
  logic             t_prev;
  logic             load_prev;
  logic             evt_edge;
  logic             pop;
  logic             full;
  logic             ovf_set;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (t_in),
    .q    (t_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // INIT spans SYNC_STAGES+1 cycles so the chain holds the real t_in level
  // before t_prev is seeded; otherwise a reset-time level of 1 would look
  // like an event.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    load_prev    = 1'b0;
    evt_edge     = 1'b0;
    case (state)
      INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt = RUN;
          load_prev = 1'b1;
        end else begin
          init_cnt_nxt = init_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        evt_edge  = t_sync ^ t_prev;
        load_prev = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_prev <= 1'b0;
    end else if (load_prev) begin
      t_prev <= t_sync;
    end
  end

  assign evt_valid = (pend_cnt != '0);
  assign pop       = evt_valid & evt_ready;
  assign full      = &pend_cnt;
  // An edge that coincides with a pop replaces the popped event, so a full
  // counter only drops when nothing leaves in the same cycle.
  assign ovf_set   = evt_edge & ~pop & full;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt <= '0;
    end else if (evt_edge && !pop && !full) begin
      pend_cnt <= pend_cnt + PEND_W'(1);
    end else if (!evt_edge && pop) begin
      pend_cnt <= pend_cnt - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_cnt <= '0;
    end else if (evt_edge) begin
      total_cnt <= total_cnt + TOT_W'(1);
    end
  end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on t_in (legal 2..4).
REQ-002 Parameter PEND_W, default 4, width of the pending-event counter; capacity 2**PEND_W-1 events.
REQ-003 Parameter TOT_W, default 16, width of the total-event counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 t_in  input  1  toggle-encoded event level from a T flip-flop; each level change is one event, asynchronous to clk.
REQ-007 evt_valid  output  1  at least one decoded event is pending.
REQ-008 evt_ready  input  1  consumer accepts one event when high with evt_valid.
REQ-009 pend_cnt  output  PEND_W  number of pending events.
REQ-010 overflow  output  1  sticky flag: an event was dropped because the pending counter was full.
REQ-011 clr_ovf  input  1  clears overflow for one cycle.
REQ-012 total_cnt  output  TOT_W  count of all detected events, including dropped ones; wraps modulo 2**TOT_W.

Function
REQ-013 t_in SHALL pass through a SYNC_STAGES-deep flop chain; only the chain output (t_sync) SHALL be used internally.
REQ-014 FSM states: INIT and RUN. INIT SHALL be entered on reset. INIT SHALL last SYNC_STAGES+1 cycles, counted by an internal counter.
REQ-015 On leaving INIT, t_prev SHALL load t_sync. The FSM SHALL enter RUN. No event SHALL be generated in INIT, whatever the level of t_in.
REQ-016 In RUN, edge = t_sync XOR t_prev. t_prev SHALL load t_sync every cycle.
REQ-017 Latency with SYNC_STAGES=2: if t_in changes before rising edge k, pend_cnt SHALL increment at edge k+2 and evt_valid SHALL be high after edge k+2.
REQ-018 evt_valid SHALL equal (pend_cnt != 0), driven from registered state only.
REQ-019 Pop = evt_valid AND evt_ready. Each pop SHALL decrement pend_cnt by 1.
REQ-020 Edge and pop in the same cycle: pend_cnt SHALL stay unchanged, and no overflow SHALL be flagged, even when pend_cnt is full.
REQ-021 Edge without pop while pend_cnt = 2**PEND_W-1: pend_cnt SHALL hold, and overflow SHALL be set the next cycle.
REQ-022 evt_ready while evt_valid is low SHALL have no effect; pend_cnt SHALL never underflow.
REQ-023 overflow SHALL remain set until clr_ovf or reset. If clr_ovf and a new overflow occur in the same cycle, set SHALL win.
REQ-024 total_cnt SHALL increment on every RUN-state edge, including dropped edges, and SHALL wrap from all-ones to 0.
REQ-025 At most one event SHALL be detected per cycle. Toggles faster than one per clk period are not required to be counted.

Reset
REQ-026 Reset SHALL force the following values: synchroniser flops 0, t_prev 0, FSM INIT, INIT counter 0, pend_cnt 0, evt_valid 0, overflow 0, total_cnt 0.
REQ-027 Reset asserted mid-operation SHALL discard pending events with no pop. Decoding SHALL restart through INIT.

Structure
REQ-028 Shared package toggle_pkg SHALL hold the FSM state enum (INIT, RUN) and the default SYNC_STAGES, PEND_W and TOT_W constants.
REQ-029 Sub-module sync_chain (parameter STAGES, with clk, reset, d, q) SHALL implement REQ-013. All other logic SHALL stay in toggle_decoder.

Verification
REQ-030 Reset release with t_in=1 held, no toggles for 20 cycles -> evt_valid=0, total_cnt=0 throughout.
REQ-031 After INIT, toggle t_in 0->1 before edge k, evt_ready=1 -> evt_valid high for exactly 1 cycle after edge k+2, total_cnt=1, pend_cnt back to 0.
REQ-032 evt_ready=0, toggle t_in 17 times, 3 cycles apart -> pend_cnt=15, overflow=1, total_cnt=17. Then clr_ovf pulse -> overflow=0, pend_cnt=15.
REQ-033 pend_cnt=15, edge coincident with pop -> pend_cnt stays 15, overflow stays 0.
REQ-034 pend_cnt=5, assert reset 1 cycle -> pend_cnt=0, evt_valid=0, FSM INIT for 3 cycles, then a fresh toggle counts 1.
REQ-035 Preload by 65535 toggles (or force total_cnt to 16'hFFFF), one more toggle -> total_cnt=0, pend_cnt behaviour unaffected.
